// File: rtl/tm_rb_pkg.sv
// Shared constants and width helpers for the reorder-buffer tag scheduler.
package tm_rb_pkg;

  localparam int NUM_TAGS_DEFAULT = 8;

  // A single-tag pool still needs a 1-bit tag so port widths stay legal.
  function automatic int tag_width(input int num_tags);
    return (num_tags > 1) ? $clog2(num_tags) : 1;
  endfunction

  function automatic int cnt_width(input int num_tags);
    return $clog2(num_tags + 1);
  endfunction

endpackage

// File: rtl/tm_rb_scoreboard.sv
// Per-tag arrival bitmap: one set port (response arrival), one clear port (release).
module tm_rb_scoreboard
  import tm_rb_pkg::*;
#(
  parameter int NUM_TAGS  = NUM_TAGS_DEFAULT,
  parameter int WIDTH_TAG = tag_width(NUM_TAGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [WIDTH_TAG-1:0] set_tag,
  input  logic                 clr_en,
  input  logic [WIDTH_TAG-1:0] clr_tag,
  input  logic [WIDTH_TAG-1:0] rd_tag,
  output logic                 rd_bit,
  output logic                 set_dup,
  output logic                 set_clr_hit
);

  logic [NUM_TAGS-1:0] bits_q;
  logic [NUM_TAGS-1:0] set_mask;
  logic [NUM_TAGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_tag] = 1'b1;
    if (clr_en) clr_mask[clr_tag] = 1'b1;
  end

  // Clear is applied after set so a same-cycle collision leaves the entry empty.
  always_ff @(posedge clk) begin
    if (rst) bits_q <= '0;
    else     bits_q <= (bits_q | set_mask) & ~clr_mask;
  end

  assign rd_bit      = bits_q[rd_tag];
  assign set_dup     = set_en & bits_q[set_tag];
  assign set_clr_hit = set_en & clr_en & (set_tag == clr_tag);

endmodule

// File: rtl/tm_rb_tag_scheduler.sv
// Circular tag allocator with in-order release of out-of-order responses
// through an externally held reorder buffer indexed by tag.
module tm_rb_tag_scheduler
  import tm_rb_pkg::*;
#(
  parameter int NUM_TAGS  = NUM_TAGS_DEFAULT,
  parameter int WIDTH_TAG = tag_width(NUM_TAGS),
  parameter int WIDTH_CNT = cnt_width(NUM_TAGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send_valid_in,
  input  logic                 send_ready_in,
  output logic                 send_ready_out,
  output logic [WIDTH_TAG-1:0] send_tag,
  input  logic                 receive_valid_in,
  input  logic [WIDTH_TAG-1:0] receive_tag,
  output logic                 receive_ready_out,
  output logic                 rb_wr_en,
  output logic [WIDTH_TAG-1:0] rb_wr_addr,
  output logic [WIDTH_TAG-1:0] rb_rd_addr,
  output logic                 receive_valid_out,
  input  logic                 receive_ready_in,
  output logic [WIDTH_CNT-1:0] outstanding,
  output logic                 tag_error
);

  logic [WIDTH_TAG-1:0] head_q;
  logic [WIDTH_TAG-1:0] tail_q;
  logic [WIDTH_CNT-1:0] outstanding_q;
  logic                 tag_error_q;

  logic                 full;
  logic                 empty;
  logic                 send_fire;
  logic                 rcv_fire;
  logic                 rel_fire;
  logic                 sb_head;
  logic                 sb_dup;
  logic                 sb_collide;
  logic [WIDTH_TAG-1:0] rcv_offset;
  logic                 out_of_window;
  logic                 err_hit;

  assign full  = (outstanding_q == WIDTH_CNT'(NUM_TAGS));
  assign empty = (outstanding_q == '0);

  assign send_ready_out = send_ready_in & ~full & ~rst;
  assign send_tag       = tail_q;
  assign send_fire      = send_valid_in & send_ready_out;

  // Every outstanding tag owns a buffer slot, so responses are never back-pressured.
  assign receive_ready_out = ~rst;
  assign rcv_fire          = receive_valid_in & receive_ready_out;
  assign rb_wr_en          = rcv_fire;
  assign rb_wr_addr        = receive_tag;

  assign rb_rd_addr        = head_q;
  assign receive_valid_out = sb_head & ~empty & ~rst;
  assign rel_fire          = receive_valid_out & receive_ready_in;

  tm_rb_scoreboard #(
    .NUM_TAGS (NUM_TAGS),
    .WIDTH_TAG(WIDTH_TAG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (rcv_fire),
    .set_tag    (receive_tag),
    .clr_en     (rel_fire),
    .clr_tag    (head_q),
    .rd_tag     (head_q),
    .rd_bit     (sb_head),
    .set_dup    (sb_dup),
    .set_clr_hit(sb_collide)
  );

  // Distance from head wraps naturally in WIDTH_TAG bits; anything at or beyond
  // the outstanding count was never issued (or already released).
  assign rcv_offset    = receive_tag - head_q;
  assign out_of_window = (WIDTH_CNT'(rcv_offset) >= outstanding_q);
  assign err_hit       = rcv_fire & (sb_dup | out_of_window | sb_collide);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      outstanding_q <= '0;
      tag_error_q   <= 1'b0;
    end else begin
      if (send_fire) tail_q <= tail_q + 1'b1;
      if (rel_fire)  head_q <= head_q + 1'b1;
      case ({send_fire, rel_fire})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
      if (err_hit) tag_error_q <= 1'b1;
    end
  end

  assign outstanding = outstanding_q;
  assign tag_error   = tag_error_q;

endmodule
